// File: rtl/des_decrypt_key_schedule_if.sv
// Key-in / subkey-out handshake bundle for the DES decryption key schedule.
// master drives key and subkey-ready; slave (the schedule) drives the rest.
interface des_decrypt_key_schedule_if;
  logic        wKeyValid;
  logic        wKeyReady;
  logic [0:63] wKey;
  logic        wSubkeyValid;
  logic        wSubkeyReady;
  logic [0:47] wSubkey;
  logic [0:3]  wRound;
  logic        wLast;

  modport master (
    output wKeyValid, wKey, wSubkeyReady,
    input  wKeyReady, wSubkeyValid, wSubkey, wRound, wLast
  );

  modport slave (
    input  wKeyValid, wKey, wSubkeyReady,
    output wKeyReady, wSubkeyValid, wSubkey, wRound, wLast
  );
endinterface

// File: rtl/des_decrypt_key_schedule.sv
// DES round subkeys in decryption order (K16..K1); K16 valid the cycle after key load.
// Backpressure: subkey/round hold while wSubkeyReady=0; keys are refused while a sequence runs.
module des_decrypt_key_schedule (
  input  logic                           wClk,
  input  logic                           wRst_n,
  des_decrypt_key_schedule_if.slave      ks
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Table entries use FIPS 1-based bit numbering.
  localparam int PC1 [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [0:47] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  state_t      state;
  logic [0:27] c_q;
  logic [0:27] d_q;
  logic [3:0]  round_q;

  logic [0:55] pc1_cd;
  logic [0:55] cd;
  logic [0:47] subkey;
  logic        rot_one;
  logic [0:27] c_rot;
  logic [0:27] d_rot;

  for (genvar i = 0; i < 56; i++) begin : g_pc1
    assign pc1_cd[i] = ks.wKey[PC1[i] - 1];
  end

  assign cd = {c_q, d_q};

  for (genvar j = 0; j < 48; j++) begin : g_pc2
    assign subkey[j] = cd[PC2[j] - 1];
  end

  // Undoing left shifts s(16)..s(2): single-bit steps fall on rounds 0, 7 and 14.
  assign rot_one = (round_q == 4'd0) || (round_q == 4'd7) || (round_q == 4'd14);
  assign c_rot   = rot_one ? {c_q[27], c_q[0:26]} : {c_q[26:27], c_q[0:25]};
  assign d_rot   = rot_one ? {d_q[27], d_q[0:26]} : {d_q[26:27], d_q[0:25]};

  always_ff @(posedge wClk or negedge wRst_n) begin
    if (!wRst_n) begin
      state   <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ks.wKeyValid) begin
            c_q     <= pc1_cd[0:27];
            d_q     <= pc1_cd[28:55];
            round_q <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          if (ks.wSubkeyReady) begin
            if (round_q == 4'd15) begin
              state <= IDLE;
            end else begin
              c_q     <= c_rot;
              d_q     <= d_rot;
              round_q <= round_q + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ks.wKeyReady    = (state == IDLE);
  assign ks.wSubkeyValid = (state == RUN);
  assign ks.wSubkey      = subkey;
  assign ks.wRound       = round_q;
  assign ks.wLast        = (state == RUN) && (round_q == 4'd15);

endmodule

// File: tb/tb_des_decrypt_key_schedule.sv
// Bench for des_decrypt_key_schedule: known-answer table, corner sequences and random keys
// against a textbook (left-shift, encryption-order) DES key-schedule model.
module tb_des_decrypt_key_schedule;

  logic wClk;
  logic wRst_n;

  des_decrypt_key_schedule_if ks();

  des_decrypt_key_schedule dut (
    .wClk   (wClk),
    .wRst_n (wRst_n),
    .ks     (ks)
  );

  initial wClk = 1'b0;
  always #5 wClk = ~wClk;

  localparam int PC1 [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2 [0:47] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SHIFTS [1:16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  localparam logic [63:0] KAT_KEY = 64'h133457799BBCDFF1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [47:0] ref_k [1:16];
  logic [47:0] got_sub   [16];
  logic [3:0]  got_round [16];
  logic        got_last  [16];
  int          got_n;
  int          cyc_used;

  typedef struct {
    logic [63:0] key;
    int          round;
    logic [47:0] sub;
    logic        last;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Encryption-order subkeys K1..K16; key bit FIPS n is key[64-n].
  task automatic model(input logic [63:0] key);
    logic c [1:28];
    logic d [1:28];
    logic tc, td;
    int   p;
    for (int i = 1; i <= 28; i++) begin
      c[i] = key[64 - PC1[i - 1]];
      d[i] = key[64 - PC1[i + 27]];
    end
    for (int r = 1; r <= 16; r++) begin
      for (int s = 0; s < SHIFTS[r]; s++) begin
        tc = c[1];
        td = d[1];
        for (int i = 1; i < 28; i++) begin
          c[i] = c[i + 1];
          d[i] = d[i + 1];
        end
        c[28] = tc;
        d[28] = td;
      end
      for (int j = 1; j <= 48; j++) begin
        p = PC2[j - 1];
        ref_k[r][48 - j] = (p <= 28) ? c[p] : d[p - 28];
      end
    end
  endtask

  task automatic load_key(input logic [63:0] k, input bit hold);
    int w;
    w = 0;
    while (!ks.wKeyReady && w < 100) begin
      @(posedge wClk); #1;
      w++;
    end
    check("load_ready", ks.wKeyReady, 1);
    ks.wKey      = k;
    ks.wKeyValid = 1'b1;
    @(posedge wClk); #1;
    if (!hold) ks.wKeyValid = 1'b0;
    check("load_latency_valid", ks.wSubkeyValid, 1);
    check("load_round0", ks.wRound, 0);
  endtask

  // Drains one sequence; verifies stall stability and ordering against ref_k.
  task automatic collect(input int pct, input bit poke);
    bit          rdy, sv, stall_prev;
    logic [47:0] s, ps;
    logic [3:0]  r, pr;
    logic        l;
    got_n      = 0;
    cyc_used   = 0;
    stall_prev = 0;
    ps = '0;
    pr = '0;
    for (int b = 0; b < 3000 && got_n < 16; b++) begin
      rdy = ($urandom_range(99) < pct);
      ks.wSubkeyReady = rdy;
      if (poke) begin
        ks.wKeyValid = 1'($urandom_range(1));
        ks.wKey      = {$urandom, $urandom};
      end
      if (stall_prev) begin
        check("stall_subkey", ks.wSubkey, ps);
        check("stall_round", ks.wRound, pr);
      end
      check("run_valid", ks.wSubkeyValid, 1);
      check("run_keyready", ks.wKeyReady, 0);
      sv = ks.wSubkeyValid;
      s  = ks.wSubkey;
      r  = ks.wRound;
      l  = ks.wLast;
      @(posedge wClk); #1;
      cyc_used++;
      if (sv && rdy) begin
        got_sub[got_n]   = s;
        got_round[got_n] = r;
        got_last[got_n]  = l;
        got_n++;
        stall_prev = 0;
      end else begin
        stall_prev = sv;
        ps = s;
        pr = r;
      end
    end
    if (got_n < 16) check("collect_timeout", got_n, 16);
    ks.wSubkeyReady = 1'b0;
    if (poke) ks.wKeyValid = 1'b0;
    check("end_valid", ks.wSubkeyValid, 0);
    check("end_keyready", ks.wKeyReady, 1);
    check("end_last", ks.wLast, 0);
    for (int i = 0; i < got_n; i++) begin
      check("seq_round", got_round[i], i);
      check("seq_last", got_last[i], (i == 15));
      check("seq_subkey", got_sub[i], ref_k[16 - i]);
    end
  endtask

  initial begin
    vecs[0] = '{key: KAT_KEY, round: 0,  sub: 48'hCB3D8B0E17F5, last: 1'b0};
    vecs[1] = '{key: KAT_KEY, round: 1,  sub: 48'hBF918D3D3F0A, last: 1'b0};
    vecs[2] = '{key: KAT_KEY, round: 14, sub: 48'h79AED9DBC9E5, last: 1'b0};
    vecs[3] = '{key: KAT_KEY, round: 15, sub: 48'h1B02EFFC7072, last: 1'b1};
    vecs[4] = '{key: 64'h0101010101010101, round: 0,  sub: 48'h000000000000, last: 1'b0};
    vecs[5] = '{key: 64'h0101010101010101, round: 15, sub: 48'h000000000000, last: 1'b1};
    vecs[6] = '{key: 64'hFEFEFEFEFEFEFEFE, round: 0,  sub: 48'hFFFFFFFFFFFF, last: 1'b0};
    vecs[7] = '{key: 64'hFEFEFEFEFEFEFEFE, round: 9,  sub: 48'hFFFFFFFFFFFF, last: 1'b0};

    ks.wKeyValid    = 1'b0;
    ks.wKey         = '0;
    ks.wSubkeyReady = 1'b0;
    wRst_n = 1'b1;
    #1 wRst_n = 1'b0;
    #2;
    check("reset_keyready", ks.wKeyReady, 1);
    check("reset_valid", ks.wSubkeyValid, 0);
    check("reset_subkey", ks.wSubkey, 0);
    check("reset_round", ks.wRound, 0);
    check("reset_last", ks.wLast, 0);
    @(negedge wClk) wRst_n = 1'b1;
    @(posedge wClk); #1;

    // Table-driven known answers and degenerate keys, full-rate drain.
    foreach (vecs[v]) begin
      model(vecs[v].key);
      load_key(vecs[v].key, 0);
      collect(100, 0);
      check("throughput_cycles", cyc_used, 16);
      check("vec_subkey", got_sub[vecs[v].round], vecs[v].sub);
      check("vec_last", got_last[vecs[v].round], vecs[v].last);
    end

    // Backpressure with ignored key pulses during RUN.
    model(KAT_KEY);
    load_key(KAT_KEY, 0);
    collect(30, 1);

    // Reset mid-sequence after 5 accepted subkeys.
    load_key(KAT_KEY, 0);
    ks.wSubkeyReady = 1'b1;
    repeat (5) @(posedge wClk);
    #1 ks.wSubkeyReady = 1'b0;
    check("mid_round5", ks.wRound, 5);
    #2 wRst_n = 1'b0;
    #1;
    check("midrst_valid", ks.wSubkeyValid, 0);
    check("midrst_keyready", ks.wKeyReady, 1);
    check("midrst_subkey", ks.wSubkey, 0);
    check("midrst_round", ks.wRound, 0);
    @(posedge wClk); #1;
    check("midrst_hold_valid", ks.wSubkeyValid, 0);
    @(negedge wClk) wRst_n = 1'b1;
    @(posedge wClk); #1;
    check("postrst_valid", ks.wSubkeyValid, 0);
    check("postrst_keyready", ks.wKeyReady, 1);
    load_key(KAT_KEY, 0);
    collect(100, 0);
    check("restart_k16", got_sub[0], 48'hCB3D8B0E17F5);

    // Back-to-back keys with wKeyValid held high throughout.
    begin
      logic [63:0] k1, k2;
      k1 = {$urandom, $urandom};
      k2 = {$urandom, $urandom};
      model(k1);
      load_key(k1, 1);
      ks.wKey = k2;
      collect(100, 0);
      @(posedge wClk); #1;
      ks.wKeyValid = 1'b0;
      check("b2b_accept_valid", ks.wSubkeyValid, 1);
      check("b2b_accept_round", ks.wRound, 0);
      model(k2);
      check("b2b_first_subkey", ks.wSubkey, ref_k[16]);
      collect(100, 0);
    end

    // Random keys, mixed ready rates.
    for (int n = 0; n < 200; n++) begin
      logic [63:0] k;
      k = {$urandom, $urandom};
      model(k);
      load_key(k, 0);
      collect((n % 2 == 0) ? 100 : 30, (n % 4 == 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
